// File: rtl/tdm_mux_8to1.sv
// rtl/tdm_mux_8to1.sv - 8-to-1 time-division multiplexer with one-frame shadow buffer
//
// Purpose: accepts a frame of eight parallel lanes via a valid/ready load
// handshake and serializes it one lane per enabled clock onto out, while
// driving the slot index SEL that steers the downstream 1-to-8 demux.
// A shadow register holds one queued frame so back-to-back frames run with
// no idle slot between them.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   en           slot advance enable (ignored while idle)
//   d0..d7       frame lanes, lane k is sent in slot k
//   load_valid   a frame is present on d0..d7
//   load_ready   a frame can be accepted this cycle
//   out          serialized lane data (0 while idle)
//   SEL          current slot index
//   out_valid    out/SEL carry a live frame slot
//   frame_start  slot 0 of a frame is being presented

module tdm_mux_8to1 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   input  logic [WIDTH-1:0] d3,
   input  logic [WIDTH-1:0] d4,
   input  logic [WIDTH-1:0] d5,
   input  logic [WIDTH-1:0] d6,
   input  logic [WIDTH-1:0] d7,
   input  logic             load_valid,
   output logic             load_ready,
   output logic [WIDTH-1:0] out,
   output logic [2:0]       SEL,
   output logic             out_valid,
   output logic             frame_start
);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [2:0]              slot_q, slot_d;
   logic [7:0][WIDTH-1:0]   active_q, active_d;
   logic [7:0][WIDTH-1:0]   shadow_q, shadow_d;
   logic                    shadow_full_q, shadow_full_d;
   logic [7:0][WIDTH-1:0]   lanes;
   logic                    accept;
   logic                    frame_end;

   // Element 0 of the packed lane vector is d0.
   assign lanes      = {d7, d6, d5, d4, d3, d2, d1, d0};
   assign load_ready = !shadow_full_q && !rst;
   assign accept     = load_valid && load_ready;
   assign frame_end  = (state_q == SEND) && en && (slot_q == 3'd7);

   always_comb begin
      state_d       = state_q;
      slot_d        = slot_q;
      active_d      = active_q;
      shadow_d      = shadow_q;
      shadow_full_d = shadow_full_q;

      if (state_q == IDLE) begin
         if (accept) begin
            active_d = lanes;
            slot_d   = 3'd0;
            state_d  = SEND;
         end
      end else if (frame_end) begin
         slot_d = 3'd0;
         if (shadow_full_q) begin
            // load_ready is low while the shadow is full, so no load can
            // compete with the shadow on this edge.
            active_d      = shadow_q;
            shadow_full_d = 1'b0;
         end else if (accept) begin
            // Shadow empty at the frame boundary: bypass it so the new
            // frame starts immediately without consuming the buffer.
            active_d = lanes;
         end else begin
            state_d = IDLE;
         end
      end else begin
         if (en) begin
            slot_d = slot_q + 3'd1;
         end
         if (accept) begin
            shadow_d      = lanes;
            shadow_full_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         slot_q        <= 3'd0;
         active_q      <= '0;
         shadow_q      <= '0;
         shadow_full_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         slot_q        <= slot_d;
         active_q      <= active_d;
         shadow_q      <= shadow_d;
         shadow_full_q <= shadow_full_d;
      end
   end

   assign out         = (state_q == SEND) ? active_q[slot_q] : '0;
   assign SEL         = slot_q;
   assign out_valid   = (state_q == SEND);
   assign frame_start = (state_q == SEND) && (slot_q == 3'd0);

endmodule

// File: tb/tb_tdm_mux_8to1.sv
// tb/tb_tdm_mux_8to1.sv - self-checking bench for tdm_mux_8to1

module tb_tdm_mux_8to1;

   typedef logic [7:0][3:0] frame_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       load_valid;
   logic [3:0] d [8];
   logic       load_ready;
   logic [3:0] dout;
   logic [2:0] sel;
   logic       out_valid;
   logic       frame_start;

   int tests = 0;
   int fails = 0;

   // Reference model: FIFO of held frames (front is the one on the line)
   // plus the position within the front frame.
   frame_t mq[$];
   int     mpos = 0;

   tdm_mux_8to1 #(.WIDTH(4)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .d0          (d[0]),
      .d1          (d[1]),
      .d2          (d[2]),
      .d3          (d[3]),
      .d4          (d[4]),
      .d5          (d[5]),
      .d6          (d[6]),
      .d7          (d[7]),
      .load_valid  (load_valid),
      .load_ready  (load_ready),
      .out         (dout),
      .SEL         (sel),
      .out_valid   (out_valid),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic frame_t cur_frame();
      frame_t f;
      for (int k = 0; k < 8; k++) f[k] = d[k];
      return f;
   endfunction

   task automatic rand_lanes();
      for (int k = 0; k < 8; k++) d[k] = 4'($urandom_range(0, 15));
   endtask

   task automatic model_edge();
      bit acc, fin;
      if (rst) begin
         mq.delete();
         mpos = 0;
      end else begin
         acc = load_valid && (mq.size() < 2);
         fin = (mq.size() > 0) && en && (mpos == 7);
         if (mq.size() > 0 && en) mpos = (mpos + 1) % 8;
         if (fin) void'(mq.pop_front());
         if (acc) mq.push_back(cur_frame());
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   // {out_valid, frame_start, load_ready, SEL, out}
   function automatic logic [9:0] exp_vec();
      frame_t     f;
      logic       v;
      logic [3:0] o;
      v = (mq.size() > 0);
      o = 4'd0;
      if (v) begin
         f = mq[0];
         o = f[mpos[2:0]];
      end
      return {v, v && (mpos == 0), (mq.size() < 2) && !rst, mpos[2:0], o};
   endfunction

   function automatic logic [9:0] obs_vec();
      return {out_valid, frame_start, load_ready, sel, dout};
   endfunction

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; load_valid = 1'b1;
      rand_lanes();
      tick();
      tick();
      tests++;
      if (obs_vec() !== 10'd0) begin
         fails++;
         $display("FAIL reset_outputs: got %b expected %b", obs_vec(), 10'd0);
      end
      rst = 1'b0; load_valid = 1'b0;
      #1;
      tests++;
      if (load_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_release_ready: got %b expected 1", load_ready);
      end
   endtask

   task automatic test_single_frame();
      int pat [8];
      pat = '{1, 0, 1, 1, 0, 0, 1, 0};
      for (int k = 0; k < 8; k++) d[k] = 4'(pat[k]);
      en = 1'b1; load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      rand_lanes();
      for (int k = 0; k < 8; k++) begin
         tests++;
         if ({out_valid, frame_start, sel, dout} !== {1'b1, k == 0, 3'(k), 4'(pat[k])}) begin
            fails++;
            $display("FAIL single_slot%0d: got v=%b fs=%b sel=%0d out=%h expected v=1 fs=%b sel=%0d out=%h",
                     k, out_valid, frame_start, sel, dout, k == 0, k, pat[k]);
         end
         tick();
      end
      tests++;
      if (out_valid !== 1'b0) begin
         fails++;
         $display("FAIL single_end_valid: got %b expected 0", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      frame_t b;
      en = 1'b1; load_valid = 1'b1;
      rand_lanes();
      tick();
      rand_lanes();
      b = cur_frame();
      tick();
      tests++;
      if (load_ready !== 1'b0) begin
         fails++;
         $display("FAIL b2b_ready_low: got %b expected 0", load_ready);
      end
      rand_lanes();   // offered while full; must be refused
      for (int i = 0; i < 6; i++) begin
         tick();
         tests++;
         if (obs_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL b2b_model: got %b expected %b", obs_vec(), exp_vec());
         end
      end
      load_valid = 1'b0;
      tests++;
      if (sel !== 3'd7) begin
         fails++;
         $display("FAIL b2b_slot7: got %0d expected 7", sel);
      end
      tick();
      tests++;
      if ({out_valid, frame_start, load_ready, sel, dout} !== {3'b111, 3'd0, b[0]}) begin
         fails++;
         $display("FAIL b2b_second_start: got %b expected %b",
                  {out_valid, frame_start, load_ready, sel, dout}, {3'b111, 3'd0, b[0]});
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         tests++;
         if (obs_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL b2b_drain: got %b expected %b", obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_en_toggle();
      logic [2:0] prev_sel;
      logic [3:0] prev_out;
      int         edges = 0;
      bit         done = 0;
      en = 1'b1; load_valid = 1'b1;
      rand_lanes();
      tick();
      load_valid = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         en = (i % 2 == 0);
         prev_sel = sel;
         prev_out = dout;
         tick();
         if (en) begin
            edges++;
         end else begin
            tests++;
            if ({sel, dout} !== {prev_sel, prev_out}) begin
               fails++;
               $display("FAIL en_hold: got sel=%0d out=%h expected sel=%0d out=%h",
                        sel, dout, prev_sel, prev_out);
            end
         end
         tests++;
         if (obs_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL en_model: got %b expected %b", obs_vec(), exp_vec());
         end
         if (!out_valid) done = 1;
      end
      tests++;
      if (!done || edges != 8) begin
         fails++;
         $display("FAIL en_frame_len: got %0d enabled edges (done=%0d) expected 8", edges, done);
      end
      en = 1'b1;
   endtask

   task automatic test_slot7_load();
      frame_t b;
      en = 1'b1; load_valid = 1'b1;
      rand_lanes();
      tick();
      load_valid = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      tests++;
      if (sel !== 3'd7 || load_ready !== 1'b1) begin
         fails++;
         $display("FAIL s7_pre: got sel=%0d ready=%b expected sel=7 ready=1", sel, load_ready);
      end
      rand_lanes();
      b = cur_frame();
      load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      tests++;
      if ({out_valid, frame_start, load_ready, sel, dout} !== {3'b111, 3'd0, b[0]}) begin
         fails++;
         $display("FAIL s7_direct: got %b expected %b",
                  {out_valid, frame_start, load_ready, sel, dout}, {3'b111, 3'd0, b[0]});
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         tests++;
         if (obs_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL s7_drain: got %b expected %b", obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_reset_mid();
      frame_t c;
      en = 1'b1; load_valid = 1'b1;
      rand_lanes();
      tick();
      rand_lanes();
      tick();
      load_valid = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      tests++;
      if (sel !== 3'd4 || load_ready !== 1'b0) begin
         fails++;
         $display("FAIL rmid_pre: got sel=%0d ready=%b expected sel=4 ready=0", sel, load_ready);
      end
      rst = 1'b1;
      tick();
      tests++;
      if (obs_vec() !== 10'd0) begin
         fails++;
         $display("FAIL rmid_cleared: got %b expected %b", obs_vec(), 10'd0);
      end
      rst = 1'b0;
      rand_lanes();
      c = cur_frame();
      load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      rand_lanes();
      for (int k = 0; k < 8; k++) begin
         tests++;
         if ({out_valid, frame_start, sel, dout} !== {1'b1, k == 0, 3'(k), c[k]}) begin
            fails++;
            $display("FAIL rmid_new_slot%0d: got v=%b fs=%b sel=%0d out=%h expected out=%h",
                     k, out_valid, frame_start, sel, dout, c[k]);
         end
         tick();
      end
      tests++;
      if (out_valid !== 1'b0) begin
         fails++;
         $display("FAIL rmid_no_stale: got %b expected 0", out_valid);
      end
   endtask

   task automatic test_width_ramp();
      for (int k = 0; k < 8; k++) d[k] = 4'(k);
      en = 1'b1; load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tests++;
         if (out_valid !== 1'b1 || dout !== {1'b0, sel} || sel !== 3'(k)) begin
            fails++;
            $display("FAIL ramp_slot%0d: got sel=%0d out=%h v=%b expected sel=%0d out=%0d",
                     k, sel, dout, out_valid, k, k);
         end
         tick();
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         rst        = ($urandom_range(0, 99) == 0);
         load_valid = ($urandom_range(0, 2) != 0);
         en         = ($urandom_range(0, 3) != 0);
         rand_lanes();
         tick();
         tests++;
         if (obs_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL random_cycle%0d: got %b expected %b", i, obs_vec(), exp_vec());
         end
      end
      rst = 1'b0; load_valid = 1'b0; en = 1'b1;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; load_valid = 1'b0;
      for (int k = 0; k < 8; k++) d[k] = 4'd0;
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_en_toggle();
      test_slot7_load();
      test_reset_mid();
      test_width_ramp();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
